// File: rtl/mem_region_ctrl.sv
// rtl/mem_region_ctrl.sv - instruction/data region decoder with a latency-counted data port
// Optional feature: define MEMCTRL_ERR_EN to report unmapped accesses and ROM writes on d_err.
module mem_region_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int unsigned IMEM_BASE = 0,
    parameter int unsigned IMEM_SIZE = 500,
    parameter int unsigned ROM_BASE  = 500,
    parameter int unsigned ROM_SIZE  = 150000,
    parameter int unsigned RAM_BASE  = 150500,
    parameter int unsigned RAM_SIZE  = 150000,
    parameter int          ROM_LAT   = 1,
    parameter int          RAM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_busy,
    output logic              d_err,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Region bounds computed wide so base+size never wraps.
    localparam longint IMEM_LO_L = longint'(IMEM_BASE);
    localparam longint IMEM_HI_L = IMEM_LO_L + longint'(IMEM_SIZE);
    localparam longint ROM_LO_L  = longint'(ROM_BASE);
    localparam longint ROM_HI_L  = ROM_LO_L + longint'(ROM_SIZE);
    localparam longint RAM_LO_L  = longint'(RAM_BASE);
    localparam longint RAM_HI_L  = RAM_LO_L + longint'(RAM_SIZE);

    localparam logic [ADDR_W:0] IMEM_LO = IMEM_LO_L[ADDR_W:0];
    localparam logic [ADDR_W:0] IMEM_HI = IMEM_HI_L[ADDR_W:0];
    localparam logic [ADDR_W:0] ROM_LO  = ROM_LO_L[ADDR_W:0];
    localparam logic [ADDR_W:0] ROM_HI  = ROM_HI_L[ADDR_W:0];
    localparam logic [ADDR_W:0] RAM_LO  = RAM_LO_L[ADDR_W:0];
    localparam logic [ADDR_W:0] RAM_HI  = RAM_HI_L[ADDR_W:0];

    localparam bit OVL_IMEM_ROM = (IMEM_SIZE != 0) && (ROM_SIZE != 0) &&
                                  (IMEM_LO_L < ROM_HI_L) && (ROM_LO_L < IMEM_HI_L);
    localparam bit OVL_IMEM_RAM = (IMEM_SIZE != 0) && (RAM_SIZE != 0) &&
                                  (IMEM_LO_L < RAM_HI_L) && (RAM_LO_L < IMEM_HI_L);
    localparam bit OVL_ROM_RAM  = (ROM_SIZE != 0) && (RAM_SIZE != 0) &&
                                  (ROM_LO_L < RAM_HI_L) && (RAM_LO_L < ROM_HI_L);

    localparam int MAX_LAT = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    // Refuse to build a map with overlapping regions or a zero wait count.
    generate
        if (OVL_IMEM_ROM || OVL_IMEM_RAM || OVL_ROM_RAM) begin : g_overlap
            $error("mem_region_ctrl: address regions overlap");
        end
        if ((ROM_LAT < 1) || (RAM_LAT < 1)) begin : g_bad_lat
            $error("mem_region_ctrl: ROM_LAT and RAM_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cap_we;
    logic             cap_rom;

    logic             pc_hit;
    logic             d_rom_hit;
    logic             d_ram_hit;

    // Half-open region test on an address widened by one bit.
    function automatic logic in_region(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W:0]   lo,
                                       input logic [ADDR_W:0]   hi);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    // Address decode for the fetch and data ports.
    always_comb begin
        pc_hit    = in_region(pc, IMEM_LO, IMEM_HI);
        d_rom_hit = in_region(d_addr, ROM_LO, ROM_HI);
        d_ram_hit = in_region(d_addr, RAM_LO, RAM_HI);
    end

    // Instruction memory offset; zero when the pc is outside the region.
    always_comb begin
        imem_addr = '0;
        if (pc_hit) begin
            imem_addr = pc - IMEM_LO[ADDR_W-1:0];
        end
    end

    // Fetch register: load on a mapped pc, hold the last instruction otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (pc_hit) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else begin
            instr_valid <= 1'b0;
        end
    end

    // Data port FSM with registered strobes, addresses and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_rom   <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            d_busy    <= 1'b0;
            d_err     <= 1'b0;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    d_valid <= 1'b0;
                    d_err   <= 1'b0;
                    if (d_req) begin
                        cap_we <= d_we;
                        d_busy <= 1'b1;
                        if (d_ram_hit) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(RAM_LAT);
                            cap_rom  <= 1'b0;
                            ram_addr <= d_addr - RAM_LO[ADDR_W-1:0];
                            if (d_we) begin
                                ram_we    <= 1'b1;
                                ram_wdata <= d_wdata;
                            end
                        end else if (d_rom_hit && !d_we) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(ROM_LAT);
                            cap_rom  <= 1'b1;
                            rom_addr <= d_addr - ROM_LO[ADDR_W-1:0];
                        end else begin
                            // Unmapped access or ROM write: answer at once, touch no memory.
                            state   <= RESP;
                            d_valid <= 1'b1;
                            d_rdata <= '0;
`ifdef MEMCTRL_ERR_EN
                            d_err   <= 1'b1;
`else
                            d_err   <= 1'b0;
`endif
                        end
                    end
                end
                WAIT: begin
                    // The write strobe only ever covers the first wait cycle.
                    ram_we <= 1'b0;
                    if (wait_cnt == CNT_W'(1)) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                        d_valid  <= 1'b1;
                        d_err    <= 1'b0;
                        if (cap_we) begin
                            d_rdata <= '0;
                        end else if (cap_rom) begin
                            d_rdata <= rom_rdata;
                        end else begin
                            d_rdata <= ram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    d_valid <= 1'b0;
                    d_err   <= 1'b0;
                    d_busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    d_valid <= 1'b0;
                    d_err   <= 1'b0;
                    d_busy  <= 1'b0;
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_region_ctrl.sv
// tb/tb_mem_region_ctrl.sv - directed self-checking bench for mem_region_ctrl
module tb_mem_region_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_busy;
    logic        d_err;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;

    logic [31:0] ram_mem [16];
    logic        exp_err;

    mem_region_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .d_busy     (d_busy),
        .d_err      (d_err),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with asynchronous reads.
    assign imem_rdata = 32'hA000_0000 | imem_addr;
    assign rom_rdata  = 32'hB000_0000 ^ rom_addr;
    assign ram_rdata  = ram_mem[ram_addr[3:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr[3:0]] <= ram_wdata;
            we_pulses <= we_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request and return cycles-to-d_valid (capped at 10), data and error.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        step();
        d_req = 1'b0;
        lat = 1;
        while (!d_valid && lat < 10) begin
            step();
            lat++;
        end
        rdata = d_rdata;
        err   = d_err;
        step();
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          vcount;
    int          pulses0;
    logic [31:0] rom_before;

    initial begin
`ifdef MEMCTRL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 16; i++) ram_mem[i] = '0;
        reset = 1'b1; pc = 32'd700; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        step();
        step();
        chk("rst_instr", instr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_err", d_err, 0);
        chk("rst_rdata", d_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;

        // Instruction fetch across the region's upper edge.
        pc = 32'd0; #1;
        chk("imem_addr_0", imem_addr, 0);
        step();
        chk("ivalid_0", instr_valid, 1);
        chk("instr_0", instr, 32'hA000_0000);
        pc = 32'd499; #1;
        chk("imem_addr_499", imem_addr, 499);
        step();
        chk("ivalid_499", instr_valid, 1);
        chk("instr_499", instr, 32'hA000_01F3);
        pc = 32'd500; #1;
        chk("imem_addr_500", imem_addr, 0);
        step();
        chk("ivalid_500", instr_valid, 0);
        chk("instr_held", instr, 32'hA000_01F3);

        // RAM write then read-back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd150500; d_wdata = 32'hDEAD_BEEF;
        step();
        d_req = 1'b0;
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 0);
        chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("wr_busy", d_busy, 1);
        step();
        chk("wr_ram_we_low", ram_we, 0);
        chk("wr_valid", d_valid, 1);
        chk("wr_rdata", d_rdata, 0);
        chk("wr_err", d_err, 0);
        step();
        chk("wr_idle", d_busy, 0);
        chk("wr_pulses", we_pulses, 1);
        access(1'b0, 32'd150500, 32'h0, lat, rdata, err);
        chk("rd_ram_lat", lat, 2);
        chk("rd_ram_data", rdata, 32'hDEAD_BEEF);
        chk("rd_ram_err", err, 0);
        chk("rd_ram_pulses", we_pulses, 1);

        // ROM reads at both ends of the region.
        access(1'b0, 32'd500, 32'h0, lat, rdata, err);
        chk("rom_lo_lat", lat, 2);
        chk("rom_lo_addr", rom_addr, 0);
        chk("rom_lo_data", rdata, 32'hB000_0000);
        access(1'b0, 32'd150499, 32'h0, lat, rdata, err);
        chk("rom_hi_lat", lat, 2);
        chk("rom_hi_addr", rom_addr, 149999);
        chk("rom_hi_data", rdata, 32'hB002_49EF);
        chk("rom_hi_err", err, 0);

        // Unmapped read and ROM write: immediate response, no memory activity.
        rom_before = rom_addr;
        access(1'b0, 32'd300500, 32'h0, lat, rdata, err);
        chk("unm_lat", lat, 1);
        chk("unm_data", rdata, 0);
        chk("unm_err", err, exp_err);
        chk("unm_pulses", we_pulses, 1);
        chk("unm_rom_addr", rom_addr, rom_before);
        access(1'b1, 32'd1000, 32'h1234_5678, lat, rdata, err);
        chk("romwr_lat", lat, 1);
        chk("romwr_data", rdata, 0);
        chk("romwr_err", err, exp_err);
        chk("romwr_pulses", we_pulses, 1);
        chk("romwr_rom_addr", rom_addr, rom_before);

        // Back-to-back requests: one transaction every three cycles.
        vcount = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd150500;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("tput_busy_%0d", i), d_busy, (i % 3) != 2);
            if (d_valid) vcount++;
        end
        d_req = 1'b0;
        chk("tput_valid_count", vcount, 3);
        step(); step(); step();
        chk("tput_drained", d_busy, 0);

        // Reset during the wait cycle of a RAM read.
        pulses0 = we_pulses;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd150501;
        step();
        d_req = 1'b0;
        chk("abort_in_wait", d_busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", d_valid, 0);
        chk("abort_busy", d_busy, 0);
        chk("abort_rdata", d_rdata, 0);
        chk("abort_err", d_err, 0);
        chk("abort_ram_addr", ram_addr, 0);
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_ram_we", ram_we, 0);
        step();
        chk("abort_no_valid", d_valid, 0);
        chk("abort_pulses", we_pulses, pulses0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
